// File: rtl/sistema_cpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sistema_cpu_div_pkg
// Purpose  : Shared types and constants for the iterative CPU divider cell.
//            - div_state_t    : divider FSM states
//            - DIV_WIDTH      : default operand/result width
//            - c_div_dbz_quot : quotient returned on divide-by-zero (all-ones)
// Revision : 1.0 - initial release
// ============================================================================
package sistema_cpu_div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] c_div_dbz_quot = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/sistema_cpu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : sistema_cpu_div_step
// Purpose  : One combinational radix-2 restoring division step.
// Ports    : i_rem      [WIDTH:0]   partial remainder in
//            i_dvd_msb              next dividend bit shifted into remainder
//            i_divisor  [WIDTH-1:0] divisor magnitude
//            o_rem      [WIDTH:0]   partial remainder out
//            o_quot_bit             quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module sistema_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_quot_bit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_shift = {i_rem, i_dvd_msb};
    assign w_diff  = w_shift - {2'b00, i_divisor};

    // The incoming remainder is always below the divisor, so the shifted
    // value fits in WIDTH+1 bits and the top bit of the difference is a
    // clean borrow: no borrow means shifted >= divisor.
    assign o_quot_bit = ~w_diff[WIDTH+1];
    assign o_rem      = o_quot_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/sistema_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : sistema_cpu_div_cell
// Purpose  : Iterative signed/unsigned integer divider, one restoring step per
//            clock, with start/busy/done handshake and flush abort.
// Ports    : clk, reset (async, active-high)
//            div_start, div_signed, div_rem_sel, div_abort   request/control
//            div_dividend, div_divisor [WIDTH-1:0]           operands
//            div_busy   high while an operation is in flight
//            div_done   one-cycle completion pulse
//            div_result [WIDTH-1:0] quotient or remainder, held
//            div_dbz    divide-by-zero flag, held with div_result
// Revision : 1.0 - initial release
// ============================================================================
module sistema_cpu_div_cell
    import sistema_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             div_rem_sel,
    input  logic             div_abort,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result,
    output logic             div_dbz
);

    localparam int                  c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0]  c_last     = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]    c_dbz_quot = {WIDTH{c_div_dbz_quot[0]}};

    div_state_t          r_state;
    logic [WIDTH:0]      r_rem;
    logic [WIDTH-1:0]    r_dvd;      // dividend, becomes quotient as it shifts
    logic [WIDTH-1:0]    r_dsr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_signed;
    logic                r_rem_sel;
    logic                r_qsign;
    logic                r_rsign;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_result;
    logic                r_dbz;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [WIDTH-1:0]    w_q_fix;
    logic [WIDTH-1:0]    w_r_fix;
    logic [WIDTH:0]      w_step_rem;
    logic                w_step_q;

    // Magnitudes: negating the most negative value wraps back to itself,
    // which read as unsigned is exactly its magnitude.
    assign w_a_neg = r_signed & r_dvd[WIDTH-1];
    assign w_b_neg = r_signed & r_dsr[WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_dvd : r_dvd;
    assign w_b_mag = w_b_neg ? -r_dsr : r_dsr;

    assign w_q_fix = r_qsign ? -r_dvd : r_dvd;
    assign w_r_fix = r_rsign ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    sistema_cpu_div_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_rem      (r_rem),
        .i_dvd_msb  (r_dvd[WIDTH-1]),
        .i_divisor  (r_dsr),
        .o_rem      (w_step_rem),
        .o_quot_bit (w_step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_rem_sel <= 1'b0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
        end else if (div_abort) begin
            // Flush wins over everything, including a same-cycle start;
            // result and dbz deliberately keep the last completed values.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (div_start) begin
                        r_dvd     <= div_dividend;
                        r_dsr     <= div_divisor;
                        r_signed  <= div_signed;
                        r_rem_sel <= div_rem_sel;
                        r_busy    <= 1'b1;
                        r_state   <= ST_PREP;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end

                ST_PREP: begin
                    if (r_dsr == '0) begin
                        r_result <= r_rem_sel ? r_dvd : c_dbz_quot;
                        r_dbz    <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_dvd   <= w_a_mag;
                        r_dsr   <= w_b_mag;
                        r_qsign <= w_a_neg ^ w_b_neg;
                        r_rsign <= w_a_neg;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    r_result <= r_rem_sel ? w_r_fix : w_q_fix;
                    r_dbz    <= 1'b0;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_DONE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_busy   = r_busy;
    assign div_done   = r_done;
    assign div_result = r_result;
    assign div_dbz    = r_dbz;

endmodule
`default_nettype wire

// File: doc/sistema_cpu_div_cell.md
# sistema_cpu_div_cell

Iterative 32-bit integer divider for the Nios II-class CPU execute/memory stage. It is the inverse arithmetic path to the CPU's partial-product multiplier cell: multi-cycle, one radix-2 restoring step per clock. It returns either quotient or remainder for `div`/`divu`-style instructions through a start/busy/done handshake, and supports pipeline-flush abort.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.

Ports:
- `clk`  in  1  : the block's single clock.
- `reset`  in  1  : asynchronous, active-high reset (decided).
- `div_start`  in  1  : request. Sampled only while `div_busy`=0.
- `div_signed`  in  1  : 1 = two's-complement operands; 0 = unsigned. Captured with `div_start`.
- `div_rem_sel`  in  1  : 1 = return remainder; 0 = return quotient. Captured with `div_start`.
- `div_abort`  in  1  : flush. Kills any operation in progress.
- `div_dividend`  in  WIDTH  : dividend. Captured with `div_start`.
- `div_divisor`  in  WIDTH  : divisor. Captured with `div_start`.
- `div_busy`  out  1  : high in PREP, ITER and FIX.
- `div_done`  out  1  : one-cycle pulse; result valid.
- `div_result`  out  WIDTH  : quotient or remainder. Held until the next completion.
- `div_dbz`  out  1  : divide-by-zero flag for the last completed operation. Held with `div_result`.

## Operation
- **States:** IDLE, PREP, ITER, FIX, DONE.
- **IDLE/DONE + `div_start` + !`div_abort`:**
  - Capture operands, `div_signed` and `div_rem_sel`.
  - Go to PREP.
- **DONE without start:** go to IDLE.
- **PREP:**
  - If divisor = 0: `div_result` = dividend when `div_rem_sel`=1, otherwise all-ones; `div_dbz`=1; go to DONE.
  - Otherwise: form unsigned magnitudes. For signed operands, |x| of 0x80000000 is 0x80000000 taken as unsigned.
  - Record the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - Clear the partial remainder; clear step count; go to ITER.
- **ITER (one step per cycle, WIDTH cycles):**
  - Partial remainder is WIDTH+1 bits wide.
  - rem = {rem, dividend msb}; shift the dividend left.
  - If rem ≥ divisor: rem -= divisor and shift in quotient bit 1; otherwise shift in 0.
  - After the step with count = WIDTH-1, go to FIX.
- **FIX:**
  - Signed mode: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Load `div_result` per `div_rem_sel`; `div_dbz`=0; go to DONE.
- **Overflow case:** signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. This falls out of the magnitude path with no special case.
- **Abort:** in any state, `div_abort`=1 sends the block to IDLE at the next edge.
  - No `div_done` is produced.
  - `div_result` and `div_dbz` keep their previous values.
  - If `div_abort` and `div_start` arrive in the same cycle, abort wins and the start is dropped.
- **`div_start` while `div_busy`=1:** ignored, with no effect.

## Timing
- **Reset values:** `div_busy`=0, `div_done`=0, `div_result`=0, `div_dbz`=0, state IDLE. Reset applies immediately, mid-operation included.
- **Normal latency:** start sampled at edge N → `div_done` high for the cycle after edge N+WIDTH+2 (34 edges for WIDTH=32).
- **Divide-by-zero latency:** `div_done` high after edge N+1.
- **`div_busy`:** rises after edge N and falls on the same edge that raises `div_done`.
- **Back-to-back:** a start may be sampled in the `div_done` cycle. Throughput is one operation per WIDTH+3 cycles.
- `div_result` and `div_dbz` change only on the edge that raises `div_done`.

## Structure
- **Package `sistema_cpu_div_pkg`:**
  - State enum.
  - `DIV_WIDTH` default constant.
  - DBZ quotient constant (all-ones).
- **Sub-module `sistema_cpu_div_step`:**
  - Combinational single restoring step.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in ITER.
- **Top:** FSM, step counter (log2(WIDTH)+1 bits), operand/sign registers, output registers.

## Test plan
- **Unsigned divide:** unsigned 100/7 → quotient 14 (`div_rem_sel`=0) and remainder 2 (`div_rem_sel`=1); `div_done` exactly 34 edges after start; `div_busy` high for 34 cycles.
- **Signed divide:** signed −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 1.
- **Divide by zero:** 5/0 → quotient 0xFFFFFFFF or remainder 5, `div_dbz`=1, `div_done` after 2 edges. A following 9/3 gives 3 with `div_dbz`=0.
- **Signed overflow:** signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_dbz`=0.
- **Abort and ignored start:**
  - Start 100/7, then pulse `div_start` again at cycle 5 with 50/5 → ignored.
  - Abort at ITER step 10 → `div_busy` low next cycle, no `div_done`, `div_result` unchanged.
  - A new start of 50/5 then completes with 10.
- **Reset mid-operation:** assert `reset` mid-ITER → all outputs at reset values immediately. After release, no `div_done` appears until a new start.
